dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port byte-addressed data memory (word access, big-endian byte order, write committed at clock edge, combinational read).
- Port 0 is the core load/store unit. Port 1 is the loader/debug path.
- Serialises requests, drives the memory enables, registers read data and returns one response per accepted request.
- Range-checks addresses.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; a legal address satisfies addr + 3 < MEM_BYTES.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  2  per-port request valid (bit i = port i)
- req_ready  out  2  per-port accept; transfer when valid & ready at the rising edge
- req_we  in  2  per-port 1 = write, 0 = read
- req_addr0 / req_addr1  in  AW  per-port byte address
- req_wdata0 / req_wdata1  in  DW  per-port write data
- rsp_valid  out  2  one-cycle response pulse to the owning port
- rsp_rdata  out  DW  read data; 0 for writes and errors
- rsp_err  out  1  out-of-range flag, qualified by rsp_valid
- mem_readEn  out  1  to memory readEn
- mem_writeEn  out  1  to memory writeEn
- mem_address  out  AW  to memory address
- mem_datain  out  DW  to memory datain
- mem_dataout  in  DW  from memory dataout

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - Choose a winner combinationally among req_valid.
  - If one port is valid, it wins.
  - If both are valid, the port != last_grant wins.
  - req_ready = one-hot of the winner; 0 if no port is valid.
  - On handshake: latch port id, we, addr, wdata into owner/op registers; set last_grant = winner; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_address = latched addr with bits [1:0] forced to 0.
  - mem_datain = latched wdata.
  - If the address is legal: mem_writeEn = we, mem_readEn = ~we.
  - If the address is illegal: both enables stay 0 and err_q is set to 1.
  - At the edge, rdata_q captures mem_dataout for a legal read; otherwise rdata_q is set to 0.
  - Next state is RESP.
- RESP (1 cycle):
  - rsp_valid[owner] = 1; rsp_rdata = rdata_q; rsp_err = err_q.
  - req_ready = 0. Next state is IDLE.
- Latency and throughput:
  - Handshake at edge N; memory access during cycle N+1; response during cycle N+2.
  - Maximum throughput is one transaction per 3 cycles.
- req_ready is 0 in ACCESS and RESP.
- Requesters hold valid and payload until accepted. Payload changes before acceptance are legal; the value at the handshake edge is the one used.
- The range check uses the full AW-bit address. An address >= MEM_BYTES-3 is an error, including wrap values such as 0xFFFFFFFC.
- Misaligned legal addresses are accepted and silently word-aligned.
- Starvation bound: a port waiting in IDLE is served on the next grant. Guaranteed wait ≤ 3 cycles after the other port's handshake.
- Reset (rst sampled high at any edge, any state):
  - state = IDLE, last_grant = 1 (port 0 wins the first tie), owner/op registers and rdata_q = 0, err_q = 0.
  - Outputs after reset: req_ready per IDLE rule, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, mem_readEn = 0, mem_writeEn = 0, mem_address = 0, mem_datain = 0.
  - Reset asserted during ACCESS suppresses the response. Memory reset clears memory contents concurrently.
- Outside ACCESS: mem_readEn = mem_writeEn = 0, and mem_address / mem_datain hold their latched values.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- When defined:
  - Adds output ports perf_grant0 (16), perf_grant1 (16) and perf_conflict (16). These are saturating counters at 16'hFFFF.
  - perf_grant0 / perf_grant1 increment on each port-0 / port-1 handshake.
  - perf_conflict increments on each cycle where both req_valid bits are 1 and at least one port is not accepted (i.e., each cycle a port waits while the other is valid).
  - All three clear on rst.
- When undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Single write then read, port 0: write addr 0x10, data 0xDEADBEEF; read addr 0x10.
  - mem_writeEn high exactly 1 cycle.
  - Read rsp_valid[0] at handshake+2 with rsp_rdata = 0xDEADBEEF, rsp_err = 0.
- Tie after reset: both ports read simultaneously (addr 0x0 / 0x4).
  - Port 0 is granted first; port 1 is granted in the next IDLE.
  - Sustained ties alternate 0, 1, 0, 1 over 8 transactions.
- Misaligned access: port 1 writes 0x12345678 to addr 0x23, then reads addr 0x20.
  - Read returns 0x12345678.
- Range check: port 0 reads addr 1021 and addr 0xFFFFFFFC; port 1 writes addr 1024.
  - Each gives rsp_err = 1, rsp_rdata = 0, and mem enables never asserted.
  - Addr 1020 succeeds with rsp_err = 0.
- Reset mid-transaction: assert rst during ACCESS of a port-1 read.
  - No rsp_valid is produced; req_ready is 2'b01 in the next cycle when both ports are valid.
- PERF (macro defined): 4 tie transactions, then 300 port-0-only transactions.
  - perf_grant0 = 302, perf_grant1 = 2.
  - perf_conflict equals the counted waiting cycles.
  - A pre-loaded counter value of 16'hFFFF holds at saturation.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory.
// Optional DMEM_ARB_PERF_EN adds saturating grant/conflict counters.
module dmem_arbiter #(
   parameter int MEM_BYTES = 1024,
   parameter int AW        = 32,
   parameter int DW        = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    req_valid,
   output logic [1:0]    req_ready,
   input  logic [1:0]    req_we,
   input  logic [AW-1:0] req_addr0,
   input  logic [AW-1:0] req_addr1,
   input  logic [DW-1:0] req_wdata0,
   input  logic [DW-1:0] req_wdata1,
   output logic [1:0]    rsp_valid,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic          mem_readEn,
   output logic          mem_writeEn,
   output logic [AW-1:0] mem_address,
   output logic [DW-1:0] mem_datain,
   input  logic [DW-1:0] mem_dataout
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [15:0]   perf_grant0,
   output logic [15:0]   perf_grant1,
   output logic [15:0]   perf_conflict
`endif
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [AW-1:0] LIMIT = AW'(MEM_BYTES - 3);

   state_t          state;
   logic            last_grant;
   logic            owner_q;
   logic            we_q;
   logic [AW-3:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic            legal_q;
   logic [DW-1:0]   rdata_q;
   logic            err_q;

   logic            win;
   logic            win_vld;
   logic            hs;
   logic            sel_we;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_wdata;
   logic            sel_legal;

   // Tie goes to the port that was not granted last.
   always_comb begin
      win     = 1'b0;
      win_vld = 1'b0;
      case (req_valid)
         2'b01: win_vld = 1'b1;
         2'b10: begin
            win     = 1'b1;
            win_vld = 1'b1;
         end
         2'b11: begin
            win     = ~last_grant;
            win_vld = 1'b1;
         end
         default: ;
      endcase
   end

   assign hs        = (state == IDLE) && win_vld;
   assign req_ready = hs ? (win ? 2'b10 : 2'b01) : 2'b00;
   assign sel_we    = win ? req_we[1] : req_we[0];
   assign sel_addr  = win ? req_addr1 : req_addr0;
   assign sel_wdata = win ? req_wdata1 : req_wdata0;
   // Full-width compare so wrap addresses like 0xFFFFFFFC are rejected.
   assign sel_legal = sel_addr < LIMIT;

   assign mem_address = {addr_q, 2'b00};
   assign mem_datain  = wdata_q;
   assign rsp_rdata   = rdata_q;
   assign rsp_err     = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         legal_q     <= 1'b0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         rsp_valid   <= 2'b00;
         mem_readEn  <= 1'b0;
         mem_writeEn <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (hs) begin
                  owner_q     <= win;
                  last_grant  <= win;
                  we_q        <= sel_we;
                  addr_q      <= sel_addr[AW-1:2];
                  wdata_q     <= sel_wdata;
                  legal_q     <= sel_legal;
                  mem_writeEn <= sel_legal & sel_we;
                  mem_readEn  <= sel_legal & ~sel_we;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               mem_writeEn <= 1'b0;
               mem_readEn  <= 1'b0;
               rdata_q     <= (legal_q && !we_q) ? mem_dataout : '0;
               err_q       <= ~legal_q;
               rsp_valid   <= owner_q ? 2'b10 : 2'b01;
               state       <= RESP;
            end
            RESP: begin
               rsp_valid <= 2'b00;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_PERF_EN
   logic conflict;

   // A cycle counts when both ports want service and one of them waits.
   assign conflict = (&req_valid) && !(&(req_valid & req_ready));

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_grant0   <= '0;
         perf_grant1   <= '0;
         perf_conflict <= '0;
      end else begin
         if (hs && !win && perf_grant0 != 16'hFFFF)
            perf_grant0 <= perf_grant0 + 16'd1;
         if (hs && win && perf_grant1 != 16'hFFFF)
            perf_grant1 <= perf_grant1 + 16'd1;
         if (conflict && perf_conflict != 16'hFFFF)
            perf_conflict <= perf_conflict + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a byte-array memory model.
// Perf counter checks are compiled in with DMEM_ARB_PERF_EN.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = '0;
   logic [1:0]  req_ready;
   logic [1:0]  req_we = '0;
   logic [31:0] req_addr0 = '0;
   logic [31:0] req_addr1 = '0;
   logic [31:0] req_wdata0 = '0;
   logic [31:0] req_wdata1 = '0;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_readEn;
   logic        mem_writeEn;
   logic [31:0] mem_address;
   logic [31:0] mem_datain;
   logic [31:0] mem_dataout;
`ifdef DMEM_ARB_PERF_EN
   logic [15:0] perf_grant0;
   logic [15:0] perf_grant1;
   logic [15:0] perf_conflict;
`endif

   dmem_arbiter dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr0(req_addr0),
      .req_addr1(req_addr1),
      .req_wdata0(req_wdata0),
      .req_wdata1(req_wdata1),
      .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .mem_readEn(mem_readEn),
      .mem_writeEn(mem_writeEn),
      .mem_address(mem_address),
      .mem_datain(mem_datain),
      .mem_dataout(mem_dataout)
`ifdef DMEM_ARB_PERF_EN
      ,
      .perf_grant0(perf_grant0),
      .perf_grant1(perf_grant1),
      .perf_conflict(perf_conflict)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct {
      int          port;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } exp_t;

   req_t pq0[$];
   req_t pq1[$];
   exp_t sb[$];
   int   gseq[$];

   logic [7:0] mem [0:1023];
   logic [7:0] ref_mem [0:1023];
   logic [9:0] ma;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int wr_cnt = 0;
   int en_cnt = 0;
   int m_busy = 0;
   int m_last = 1;
   int m_g0 = 0;
   int m_g1 = 0;
   int m_conf = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory: combinational big-endian read, write at the clock edge.
   assign ma = mem_address[9:0];
   assign mem_dataout = (mem_address <= 32'd1020) ?
      {mem[ma], mem[ma+10'd1], mem[ma+10'd2], mem[ma+10'd3]} : 32'h0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_writeEn && mem_address <= 32'd1020) begin
         mem[ma]       = mem_datain[31:24];
         mem[ma+10'd1] = mem_datain[23:16];
         mem[ma+10'd2] = mem_datain[15:8];
         mem[ma+10'd3] = mem_datain[7:0];
      end
   end

   exp_t me;
   always @(negedge clk) begin
      if (mem_writeEn) wr_cnt++;
      if (mem_writeEn || mem_readEn) en_cnt++;
      if (rsp_valid != 2'b00) begin
         if (sb.size() == 0) begin
            chk("rsp_unexpected", 32'(rsp_valid), 32'h0);
         end else begin
            me = sb.pop_front();
            chk("rsp_port", 32'(rsp_valid), 32'(1 << me.port));
            chk("rsp_rdata", rsp_rdata, me.rdata);
            chk("rsp_err", 32'(rsp_err), 32'(me.err));
            chk("rsp_latency", 32'(cyc), 32'(me.cyc));
         end
      end
   end

   task automatic push_exp(int p, req_t r);
      exp_t e;
      logic ok;
      int   a;
      ok = r.addr < 32'd1021;
      a  = int'(r.addr[9:2]) * 4;
      e.port  = p;
      e.cyc   = cyc + 2;
      e.err   = !ok;
      e.rdata = 32'h0;
      if (ok && r.we) begin
         ref_mem[a]   = r.wdata[31:24];
         ref_mem[a+1] = r.wdata[23:16];
         ref_mem[a+2] = r.wdata[15:8];
         ref_mem[a+3] = r.wdata[7:0];
      end
      if (ok && !r.we)
         e.rdata = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
      sb.push_back(e);
   endtask

   // One cycle: drive pending requests, check ready against the model.
   task automatic step();
      logic [1:0] v;
      int w;
      req_t r;
      @(negedge clk);
      v = {pq1.size() != 0, pq0.size() != 0};
      req_valid = v;
      if (v[0]) begin
         req_we[0]  = pq0[0].we;
         req_addr0  = pq0[0].addr;
         req_wdata0 = pq0[0].wdata;
      end
      if (v[1]) begin
         req_we[1]  = pq1[0].we;
         req_addr1  = pq1[0].addr;
         req_wdata1 = pq1[0].wdata;
      end
      if (v == 2'b11) m_conf++;
      #1;
      if (m_busy > 0) begin
         chk("ready_busy", 32'(req_ready), 32'h0);
         m_busy--;
      end else begin
         w = -1;
         case (v)
            2'b01: w = 0;
            2'b10: w = 1;
            2'b11: w = (m_last == 1) ? 0 : 1;
            default: w = -1;
         endcase
         chk("ready_idle", 32'(req_ready), (w < 0) ? 32'h0 : 32'(1 << w));
         if (w >= 0) begin
            r = (w == 1) ? pq1.pop_front() : pq0.pop_front();
            push_exp(w, r);
            gseq.push_back(w);
            m_last = w;
            m_busy = 2;
            if (w == 0) m_g0++;
            else m_g1++;
         end
      end
   endtask

   task automatic run(int lim);
      int k;
      k = 0;
      while ((pq0.size() != 0 || pq1.size() != 0 || m_busy > 0) && k < lim) begin
         step();
         k++;
      end
      if (k >= lim) chk("run_timeout", 32'(k), 32'(lim - 1));
      step();
      req_valid = 2'b00;
   endtask

   task automatic rd(int p, logic [31:0] a);
      req_t r;
      r.we = 1'b0;
      r.addr = a;
      r.wdata = 32'h0;
      if (p == 0) pq0.push_back(r);
      else pq1.push_back(r);
   endtask

   task automatic wr(int p, logic [31:0] a, logic [31:0] d);
      req_t r;
      r.we = 1'b1;
      r.addr = a;
      r.wdata = d;
      if (p == 0) pq0.push_back(r);
      else pq1.push_back(r);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req_valid = 2'b00;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      m_last = 1;
      m_busy = 0;
      m_g0 = 0;
      m_g1 = 0;
      m_conf = 0;
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 8'((i * 7 + 3) & 255);
         ref_mem[i] = 8'((i * 7 + 3) & 255);
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(rsp_err), 32'h0);
      chk("rst_mem_en", 32'({mem_readEn, mem_writeEn}), 32'h0);
      chk("rst_mem_addr", mem_address, 32'h0);
      chk("rst_mem_din", mem_datain, 32'h0);

      // Sustained ties right after reset
      gseq.delete();
      for (int i = 0; i < 4; i++) begin
         rd(0, 32'(8 * i));
         rd(1, 32'(8 * i + 4));
      end
      run(200);
      chk("tie_count", 32'(gseq.size()), 32'd8);
      for (int i = 0; i < gseq.size(); i++)
         chk("tie_order", 32'(gseq[i]), 32'(i % 2));

      // Port 0 write then read
      e0 = wr_cnt;
      wr(0, 32'h10, 32'hDEADBEEF);
      run(50);
      chk("wr_en_cycles", 32'(wr_cnt - e0), 32'd1);
      rd(0, 32'h10);
      run(50);
      chk("mem_word_0x10",
          {mem[16], mem[17], mem[18], mem[19]}, 32'hDEADBEEF);

      // Misaligned write is word-aligned
      wr(1, 32'h23, 32'h12345678);
      rd(1, 32'h20);
      run(50);
      chk("mem_word_0x20",
          {mem[32], mem[33], mem[34], mem[35]}, 32'h12345678);

      // Range check
      e0 = en_cnt;
      rd(0, 32'd1021);
      rd(0, 32'hFFFFFFFC);
      wr(1, 32'd1024, 32'hA5A5A5A5);
      run(100);
      chk("err_no_enable", 32'(en_cnt - e0), 32'd0);
      e0 = en_cnt;
      rd(0, 32'd1020);
      run(50);
      chk("edge_enable", 32'(en_cnt - e0), 32'd1);

      // Random mix on both ports
      for (int i = 0; i < 24; i++) begin
         logic [31:0] a;
         a = ($urandom_range(0, 7) == 0) ? 32'd1022 :
             32'h100 + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 1) == 1) wr($urandom_range(0, 1), a, $urandom);
         else rd($urandom_range(0, 1), a);
      end
      run(400);

      // Reset during ACCESS of a port-1 read
      rd(1, 32'h40);
      step();
      @(negedge clk);
      rst = 1'b1;
      req_valid = 2'b11;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_mid_ready", 32'(req_ready), 32'h1);
      chk("rst_mid_rsp", 32'(rsp_valid), 32'h0);
      req_valid = 2'b00;
      m_last = 1;
      m_busy = 0;
      @(negedge clk);
      #1;
      chk("rst_mid_rsp2", 32'(rsp_valid), 32'h0);
      step();
      step();

`ifdef DMEM_ARB_PERF_EN
      do_reset();
      #1;
      chk("perf_rst_g0", 32'(perf_grant0), 32'h0);
      chk("perf_rst_conf", 32'(perf_conflict), 32'h0);
      for (int i = 0; i < 2; i++) begin
         rd(0, 32'(8 * i));
         rd(1, 32'(8 * i + 4));
      end
      for (int i = 0; i < 300; i++) rd(0, 32'(4 * (i % 200)));
      run(2000);
      chk("perf_g0", 32'(perf_grant0), 32'd302);
      chk("perf_g1", 32'(perf_grant1), 32'd2);
      chk("perf_g0_model", 32'(perf_grant0), 32'(m_g0));
      chk("perf_conf", 32'(perf_conflict), 32'(m_conf));
      for (int i = 0; i < 11000; i++) begin
         rd(0, 32'h0);
         rd(1, 32'h4);
      end
      run(70000);
      chk("perf_conf_sat", 32'(perf_conflict), 32'hFFFF);
      chk("perf_conf_model", 32'(perf_conflict),
          (m_conf > 65535) ? 32'hFFFF : 32'(m_conf));
      chk("perf_g0_after", 32'(perf_grant0), 32'(m_g0));
      step();
      chk("perf_conf_hold", 32'(perf_conflict), 32'hFFFF);
`endif

      chk("sb_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
